ball2_survival_mode_collisiondetector: RTL and testbench
========================================================

// Module: ball2_survival_mode_collisionDetector
// PURPOSE
//  Upstream of the survival-mode ball mover. Gathers pixel overlaps between the ball sprite and each scene
//  object over one scanned frame, then sends one-clock collision pulses plus a frame-wide HitEdgeCode.
//  Pulses go out one cycle after startOfFrame, so they never share a cycle with the mover's SOF position update.
//  Also applies a wormhole re-entry cooldown and keeps a saturating bumper-hit counter for scoring.
// PARAMETERS
//  BALL_WIDTH          16  ball sprite width in pixels; offsetX range is 0..BALL_WIDTH-1
//  BALL_HEIGHT         16  ball sprite height in pixels; offsetY range is 0..BALL_HEIGHT-1
//  EDGE_WIDTH           3  pixel depth of each edge band used to classify HitEdgeCode
//  WORMHOLE_COOLDOWN   30  number of frames wormhole collisions are suppressed after a wormhole pulse
// PORTS
//  clk                      in   1  system clock
//  resetN                   in   1  asynchronous reset, active low
//  startOfFrame             in   1  one-clock pulse at the start of each frame
//  ballDrawingRequest       in   1  ball sprite is opaque at the current pixel
//  offsetX                  in   4  column of the current pixel inside the ball sprite
//  offsetY                  in   4  row of the current pixel inside the ball sprite
//  bracketsDR               in   1  current pixel is part of the border brackets
//  obstacleDR               in   1  current pixel is part of a static obstacle
//  bumperDR                 in   1  current pixel is part of a bumper
//  movingObstacleDR         in   1  current pixel is part of the moving obstacle
//  wormhole1DR              in   1  current pixel is part of wormhole 1
//  wormhole2DR              in   1  current pixel is part of wormhole 2
//  leftFlipperDR            in   1  current pixel is part of the left flipper
//  rightFlipperDR           in   1  current pixel is part of the right flipper
//  gameOver                 in   1  level input from the mover; synchronous clear
//  startGame                in   1  one-clock pulse; synchronous clear
//  collisionBrackets        out  1  brackets collision pulse
//  collisionObstacle        out  1  obstacle collision pulse
//  collisionBumper          out  1  bumper collision pulse
//  collisionMovingObstacle  out  1  moving-obstacle collision pulse
//  collisionWormhole1       out  1  wormhole 1 collision pulse
//  collisionWormhole2       out  1  wormhole 2 collision pulse
//  collisionLeftFlipper     out  1  left-flipper collision pulse
//  collisionRightFlipper    out  1  right-flipper collision pulse
//  HitEdgeCode              out  4  [3]=left, [2]=top, [1]=right, [0]=bottom; held between emits
//  bumperHitCount           out  8  number of frames with a bumper hit, saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0, accumulators 0, cooldown counter 0, FSM in SCAN.
//  - Overlap at a pixel for object k is ballDrawingRequest && kDR.
//  - Edge bits of an overlapping pixel: L = offsetX < EDGE_WIDTH; R = offsetX >= BALL_WIDTH-EDGE_WIDTH;
//    T = offsetY < EDGE_WIDTH; B = offsetY >= BALL_HEIGHT-EDGE_WIDTH.
//  - SCAN: per-object hit flags OR-accumulate; a single shared edge accumulator ORs the edge bits of
//    every overlapping pixel, whatever the object.
//  - On startOfFrame, in the same clock:
//    - accumulators are copied to shadow registers;
//    - accumulators are reloaded with that cycle's own overlap contribution, which counts toward the new frame;
//    - FSM moves to EMIT.
//  - EMIT (exactly one clock, at SOF+1):
//    - each collision output = its shadow flag;
//    - HitEdgeCode <= shadow edge code, held until the next EMIT; it is 0 if the frame had no collision;
//    - FSM returns to SCAN.
//    Collision outputs are 0 in every other cycle.
//  - Wormholes:
//    - if both flags are set in one frame, only collisionWormhole1 pulses;
//    - cooldown>0 forces both wormhole pulses to 0;
//    - a wormhole pulse loads cooldown = WORMHOLE_COOLDOWN;
//    - otherwise cooldown decrements on each startOfFrame while nonzero.
//  - bumperHitCount increments by 1 in each EMIT cycle that has collisionBumper=1, and saturates at 255.
//  - startOfFrame during EMIT is not allowed; frames are far longer than 2 cycles.
//  - gameOver=1 or startGame=1:
//    - accumulators, shadows, HitEdgeCode, cooldown and bumperHitCount clear to 0;
//    - FSM goes to SCAN and no pulse is emitted that cycle.
//    - If this coincides with startOfFrame, the clear wins.
//  - Asserting resetN low at any point returns everything to the reset state immediately.
// TESTING
//  - Ball overlaps bumperDR only at offsetY=15, offsetX=7, then SOF ->
//    collisionBumper=1 for exactly one clock at SOF+1; HitEdgeCode=4'b0001; bumperHitCount=1.
//  - Brackets overlap at (offsetX,offsetY)=(0,5) and (0,0) in one frame ->
//    collisionBrackets single pulse; HitEdgeCode=4'b1100.
//  - wormhole1DR and wormhole2DR both overlap in frame N ->
//    only collisionWormhole1 pulses; identical overlaps in frames N+1..N+30 give no wormhole pulse;
//    frame N+31 pulses again.
//  - Overlap only in the SOF cycle of frame N ->
//    no pulse at SOF(N)+1; pulse at SOF(N+1)+1.
//  - 256 consecutive frames with a bumper hit ->
//    bumperHitCount=255, then stays at 255; startGame pulse -> 0.
//  - gameOver coinciding with SOF after a hit frame ->
//    no pulse, HitEdgeCode=0; resetN low mid-SCAN clears all outputs asynchronously.

Source files
------------

// File: rtl/ball2_survival_mode_collisiondetector_if.sv
`default_nettype none
// ============================================================================
// Module   : ball2_survival_mode_collisiondetector_if
// Brief    : Pixel-scan inputs and collision outputs of the survival-mode
//            collision detector, grouped as one bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ball2_survival_mode_collisiondetector_if;
  logic       startOfFrame;
  logic       ballDrawingRequest;
  logic [3:0] offsetX;
  logic [3:0] offsetY;
  logic       bracketsDR;
  logic       obstacleDR;
  logic       bumperDR;
  logic       movingObstacleDR;
  logic       wormhole1DR;
  logic       wormhole2DR;
  logic       leftFlipperDR;
  logic       rightFlipperDR;
  logic       gameOver;
  logic       startGame;
  logic       collisionBrackets;
  logic       collisionObstacle;
  logic       collisionBumper;
  logic       collisionMovingObstacle;
  logic       collisionWormhole1;
  logic       collisionWormhole2;
  logic       collisionLeftFlipper;
  logic       collisionRightFlipper;
  logic [3:0] HitEdgeCode;
  logic [7:0] bumperHitCount;

  modport master (
    output startOfFrame, ballDrawingRequest, offsetX, offsetY,
           bracketsDR, obstacleDR, bumperDR, movingObstacleDR,
           wormhole1DR, wormhole2DR, leftFlipperDR, rightFlipperDR,
           gameOver, startGame,
    input  collisionBrackets, collisionObstacle, collisionBumper,
           collisionMovingObstacle, collisionWormhole1, collisionWormhole2,
           collisionLeftFlipper, collisionRightFlipper,
           HitEdgeCode, bumperHitCount
  );

  modport slave (
    input  startOfFrame, ballDrawingRequest, offsetX, offsetY,
           bracketsDR, obstacleDR, bumperDR, movingObstacleDR,
           wormhole1DR, wormhole2DR, leftFlipperDR, rightFlipperDR,
           gameOver, startGame,
    output collisionBrackets, collisionObstacle, collisionBumper,
           collisionMovingObstacle, collisionWormhole1, collisionWormhole2,
           collisionLeftFlipper, collisionRightFlipper,
           HitEdgeCode, bumperHitCount
  );
endinterface
`default_nettype wire

// File: rtl/ball2_survival_mode_collisiondetector.sv
`default_nettype none
// ============================================================================
// Module   : ball2_survival_mode_collisiondetector
// Brief    : Accumulates ball/object pixel overlaps over a frame and emits
//            one-clock collision pulses plus an edge code one cycle after SOF.
// Revision : 1.0 - initial release
// ============================================================================
module ball2_survival_mode_collisiondetector #(
  parameter int BALL_WIDTH        = 16,
  parameter int BALL_HEIGHT       = 16,
  parameter int EDGE_WIDTH        = 3,
  parameter int WORMHOLE_COOLDOWN = 30
) (
  input  wire logic                                  clk,
  input  wire logic                                  resetN,
  ball2_survival_mode_collisiondetector_if.slave     bus
);

  localparam int         c_CD_W     = $clog2(WORMHOLE_COOLDOWN + 1);
  localparam logic [3:0] c_EDGE     = 4'(EDGE_WIDTH);
  localparam logic [3:0] c_RIGHT    = 4'(BALL_WIDTH - EDGE_WIDTH);
  localparam logic [3:0] c_BOTTOM   = 4'(BALL_HEIGHT - EDGE_WIDTH);
  localparam logic [c_CD_W-1:0] c_COOLDOWN = c_CD_W'(WORMHOLE_COOLDOWN);
  localparam logic [c_CD_W-1:0] c_CD_ONE   = c_CD_W'(1);

  localparam int c_BUMPER = 2;
  localparam int c_WH1    = 4;
  localparam int c_WH2    = 5;

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_acc;
  logic [3:0]          r_edge_acc;
  logic [7:0]          r_shadow;
  logic [3:0]          r_shadow_edge;
  logic [3:0]          r_hit_edge;
  logic [c_CD_W-1:0]   r_cooldown;
  logic [7:0]          r_bump_cnt;

  logic [7:0]          w_dr;
  logic [7:0]          w_hit;
  logic [3:0]          w_pix_edge;
  logic [3:0]          w_edge;
  logic [7:0]          w_frame_flags;
  logic [7:0]          w_coll;
  logic                w_clear;
  logic                w_sof;
  logic                w_cd_idle;

  assign w_dr = {bus.rightFlipperDR, bus.leftFlipperDR, bus.wormhole2DR, bus.wormhole1DR,
                 bus.movingObstacleDR, bus.bumperDR, bus.obstacleDR, bus.bracketsDR};
  assign w_hit      = bus.ballDrawingRequest ? w_dr : 8'h00;
  assign w_pix_edge = {bus.offsetX < c_EDGE, bus.offsetY < c_EDGE,
                       bus.offsetX >= c_RIGHT, bus.offsetY >= c_BOTTOM};
  assign w_edge     = (|w_hit) ? w_pix_edge : 4'h0;
  assign w_clear    = bus.gameOver | bus.startGame;
  assign w_sof      = (r_state == ST_SCAN) && bus.startOfFrame;
  assign w_cd_idle  = (r_cooldown == '0);

  // Wormhole masking is decided with the cooldown value seen at SOF, before it decrements.
  always_comb begin
    w_frame_flags        = r_acc;
    w_frame_flags[c_WH1] = r_acc[c_WH1] & w_cd_idle;
    w_frame_flags[c_WH2] = r_acc[c_WH2] & ~r_acc[c_WH1] & w_cd_idle;
  end

  always_comb begin
    w_state_next = r_state;
    w_coll       = 8'h00;
    case (r_state)
      ST_SCAN: if (bus.startOfFrame) w_state_next = ST_EMIT;
      ST_EMIT: begin
        w_state_next = ST_SCAN;
        w_coll       = r_shadow;
      end
    endcase
    if (w_clear) begin
      w_state_next = ST_SCAN;
      w_coll       = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= ST_SCAN;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc         <= 8'h00;
      r_edge_acc    <= 4'h0;
      r_shadow      <= 8'h00;
      r_shadow_edge <= 4'h0;
      r_hit_edge    <= 4'h0;
      r_cooldown    <= '0;
      r_bump_cnt    <= 8'h00;
    end else if (w_clear) begin
      r_acc         <= 8'h00;
      r_edge_acc    <= 4'h0;
      r_shadow      <= 8'h00;
      r_shadow_edge <= 4'h0;
      r_hit_edge    <= 4'h0;
      r_cooldown    <= '0;
      r_bump_cnt    <= 8'h00;
    end else begin
      if (w_sof) begin
        r_shadow      <= w_frame_flags;
        r_shadow_edge <= r_edge_acc;
        r_acc         <= w_hit;
        r_edge_acc    <= w_edge;
        if (!w_cd_idle) r_cooldown <= r_cooldown - c_CD_ONE;
      end else begin
        r_acc      <= r_acc | w_hit;
        r_edge_acc <= r_edge_acc | w_edge;
      end
      if (r_state == ST_EMIT) begin
        r_hit_edge <= r_shadow_edge;
        if (r_shadow[c_WH1] | r_shadow[c_WH2]) r_cooldown <= c_COOLDOWN;
        if (r_shadow[c_BUMPER] && (r_bump_cnt != 8'hFF)) r_bump_cnt <= r_bump_cnt + 8'd1;
      end
    end
  end

  assign bus.collisionBrackets       = w_coll[0];
  assign bus.collisionObstacle       = w_coll[1];
  assign bus.collisionBumper         = w_coll[2];
  assign bus.collisionMovingObstacle = w_coll[3];
  assign bus.collisionWormhole1      = w_coll[4];
  assign bus.collisionWormhole2      = w_coll[5];
  assign bus.collisionLeftFlipper    = w_coll[6];
  assign bus.collisionRightFlipper   = w_coll[7];
  assign bus.HitEdgeCode             = r_hit_edge;
  assign bus.bumperHitCount          = r_bump_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ball2_survival_mode_collisiondetector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball2_survival_mode_collisiondetector
// Brief    : Vector table, directed corner sequences and random frames checked
//            against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball2_survival_mode_collisiondetector;

  logic clk;
  logic resetN;
  int   checks = 0;
  int   errors = 0;

  ball2_survival_mode_collisiondetector_if bus ();

  ball2_survival_mode_collisiondetector dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sof;
    logic       bdr;
    logic [3:0] ox;
    logic [3:0] oy;
    logic [7:0] drs;
    logic       clr;
    logic [7:0] e_coll;
    logic [3:0] e_edge;
    logic [7:0] e_cnt;
  } vec_t;

  // Reference model: frame-indexed, with cooldown expressed as frames since last wormhole pulse.
  logic [7:0] m_acc, m_pend_flags, m_coll;
  logic [3:0] m_acc_edge, m_pend_edge, m_edge;
  bit         m_pend;
  int         m_cnt, m_frame, m_last_wh;

  function automatic logic [7:0] dut_coll();
    return {bus.collisionRightFlipper, bus.collisionLeftFlipper, bus.collisionWormhole2,
            bus.collisionWormhole1, bus.collisionMovingObstacle, bus.collisionBumper,
            bus.collisionObstacle, bus.collisionBrackets};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_pend_flags = 0; m_coll = 0;
    m_acc_edge = 0; m_pend_edge = 0; m_edge = 0;
    m_pend = 0; m_cnt = 0; m_frame = 0; m_last_wh = -1000;
  endtask

  task automatic model_step(input logic sof, input logic bdr, input logic [3:0] ox,
                            input logic [3:0] oy, input logic [7:0] drs, input logic clr);
    logic [7:0] hit;
    logic [3:0] e;
    int x, y;
    bit allowed;
    x = int'(ox); y = int'(oy);
    hit = bdr ? drs : 8'h00;
    e = 4'h0;
    if (hit != 0) e = {x < 3, y < 3, x >= 16 - 3, y >= 16 - 3};
    if (clr) begin
      model_reset();
    end else if (m_pend) begin
      m_edge = m_pend_edge;
      if (m_pend_flags[2]) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_pend_flags[5:4] != 0) m_last_wh = m_frame;
      m_coll = 0; m_pend = 0;
      m_acc |= hit; m_acc_edge |= e;
    end else if (sof) begin
      m_frame++;
      allowed = (m_frame - m_last_wh) > 30;
      m_pend_flags = m_acc;
      m_pend_flags[4] = allowed && m_acc[4];
      m_pend_flags[5] = allowed && m_acc[5] && !m_acc[4];
      m_pend_edge = m_acc_edge;
      m_coll = m_pend_flags; m_pend = 1;
      m_acc = hit; m_acc_edge = e;
    end else begin
      m_acc |= hit; m_acc_edge |= e;
    end
  endtask

  task automatic drive(input logic sof, input logic bdr, input logic [3:0] ox, input logic [3:0] oy,
                       input logic [7:0] drs, input logic go, input logic sg);
    bus.startOfFrame = sof;       bus.ballDrawingRequest = bdr;
    bus.offsetX = ox;             bus.offsetY = oy;
    bus.bracketsDR = drs[0];      bus.obstacleDR = drs[1];
    bus.bumperDR = drs[2];        bus.movingObstacleDR = drs[3];
    bus.wormhole1DR = drs[4];     bus.wormhole2DR = drs[5];
    bus.leftFlipperDR = drs[6];   bus.rightFlipperDR = drs[7];
    bus.gameOver = go;            bus.startGame = sg;
  endtask

  task automatic tick(input logic sof, input logic bdr, input logic [3:0] ox, input logic [3:0] oy,
                      input logic [7:0] drs, input logic go, input logic sg);
    drive(sof, bdr, ox, oy, drs, go, sg);
    @(posedge clk);
    model_step(sof, bdr, ox, oy, drs, go | sg);
    #1;
    check("model_coll",  32'(dut_coll()),          32'(m_coll));
    check("model_edge",  32'(bus.HitEdgeCode),     32'(m_edge));
    check("model_count", 32'(bus.bumperHitCount),  32'(m_cnt));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] drs, input logic [3:0] ox, input logic [3:0] oy,
                           output logic [7:0] pulse);
    tick(1'b0, 1'b1, ox, oy, drs, 1'b0, 1'b0);
    idle();
    tick(1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    pulse = dut_coll();
    idle();
  endtask

  vec_t       tbl[28];
  logic [7:0] pulse;
  bit         prev_sof;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 4'd7,  4'd15, 8'h04, 1'b0, 8'h00, 4'h0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h04, 4'h0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h1, 8'd1};
    tbl[4]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h1, 8'd1};
    tbl[5]  = '{1'b0, 1'b1, 4'd0,  4'd5,  8'h01, 1'b0, 8'h00, 4'h1, 8'd1};
    tbl[6]  = '{1'b0, 1'b1, 4'd0,  4'd0,  8'h01, 1'b0, 8'h00, 4'h1, 8'd1};
    tbl[7]  = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h01, 4'h1, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'hC, 8'd1};
    tbl[9]  = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'hC, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd1};
    tbl[12] = '{1'b1, 1'b1, 4'd8,  4'd8,  8'h02, 1'b0, 8'h00, 4'h0, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd1};
    tbl[14] = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h02, 4'h0, 8'd1};
    tbl[15] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd1};
    tbl[16] = '{1'b0, 1'b1, 4'd0,  4'd0,  8'h04, 1'b0, 8'h00, 4'h0, 8'd1};
    tbl[17] = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b1, 8'h00, 4'h0, 8'd0};
    tbl[18] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd0};
    tbl[19] = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd0};
    tbl[20] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd0};
    tbl[21] = '{1'b0, 1'b1, 4'd13, 4'd13, 8'h08, 1'b0, 8'h00, 4'h0, 8'd0};
    tbl[22] = '{1'b0, 1'b1, 4'd12, 4'd2,  8'h40, 1'b0, 8'h00, 4'h0, 8'd0};
    tbl[23] = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h48, 4'h0, 8'd0};
    tbl[24] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h7, 8'd0};
    tbl[25] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h80, 1'b0, 8'h00, 4'h7, 8'd0};
    tbl[26] = '{1'b1, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h7, 8'd0};
    tbl[27] = '{1'b0, 1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 8'h00, 4'h0, 8'd0};

    resetN = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_coll",  32'(dut_coll()),         32'h0);
    check("reset_edge",  32'(bus.HitEdgeCode),    32'h0);
    check("reset_count", 32'(bus.bumperHitCount), 32'h0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 28; i++) begin
      tick(tbl[i].sof, tbl[i].bdr, tbl[i].ox, tbl[i].oy, tbl[i].drs, tbl[i].clr, 1'b0);
      check($sformatf("tbl%0d_coll", i),  32'(dut_coll()),         32'(tbl[i].e_coll));
      check($sformatf("tbl%0d_edge", i),  32'(bus.HitEdgeCode),    32'(tbl[i].e_edge));
      check($sformatf("tbl%0d_count", i), 32'(bus.bumperHitCount), 32'(tbl[i].e_cnt));
    end

    // Wormhole priority and cooldown window.
    tick(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    run_frame(8'h30, 4'd5, 4'd5, pulse);
    check("wh_first", 32'(pulse), 32'h10);
    for (int k = 1; k <= 30; k++) begin
      run_frame(8'h30, 4'd5, 4'd5, pulse);
      check($sformatf("wh_cool%0d", k), 32'(pulse[5:4]), 32'h0);
    end
    run_frame(8'h30, 4'd5, 4'd5, pulse);
    check("wh_reopen", 32'(pulse), 32'h10);

    // Bumper counter saturation.
    tick(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    for (int f = 1; f <= 256; f++) begin
      run_frame(8'h04, 4'd7, 4'd15, pulse);
      if (f == 255) check("sat_255", 32'(bus.bumperHitCount), 32'd255);
    end
    check("sat_hold", 32'(bus.bumperHitCount), 32'd255);
    tick(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    check("sat_clear", 32'(bus.bumperHitCount), 32'd0);

    // gameOver during the emit cycle suppresses the pulse and the count.
    tick(1'b0, 1'b1, 4'd0, 4'd0, 8'h04, 1'b0, 1'b0);
    idle();
    tick(1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    check("go_emit_pulse", 32'(dut_coll()), 32'h04);
    bus.gameOver = 1'b1;
    #1;
    check("go_emit_gated", 32'(dut_coll()), 32'h0);
    tick(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b1, 1'b0);
    check("go_emit_count", 32'(bus.bumperHitCount), 32'd0);

    // Asynchronous reset while a pulse is on the outputs.
    run_frame(8'h04, 4'd0, 4'd0, pulse);
    tick(1'b0, 1'b1, 4'd0, 4'd0, 8'h04, 1'b0, 1'b0);
    idle();
    tick(1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    check("ar_pre_pulse", 32'(dut_coll()), 32'h04);
    check("ar_pre_count", 32'(bus.bumperHitCount), 32'd1);
    resetN = 1'b0;
    #1;
    check("ar_coll",  32'(dut_coll()),         32'h0);
    check("ar_edge",  32'(bus.HitEdgeCode),    32'h0);
    check("ar_count", 32'(bus.bumperHitCount), 32'h0);
    model_reset();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Random frames against the model.
    prev_sof = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic       s, b, g;
      logic [7:0] d;
      s = !prev_sof && ($urandom_range(0, 15) == 0);
      b = 1'($urandom_range(0, 1));
      d = 8'($urandom) & 8'($urandom) & 8'($urandom);
      g = ($urandom_range(0, 399) == 0);
      tick(s, b, 4'($urandom), 4'($urandom), d, g, 1'b0);
      prev_sof = s;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
